// File: rtl/connect4_pkg.sv
// Shared types and constants for the connect-4 turn arbiter and its datapath neighbours.
package connect4_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2
  } player_t;

  typedef logic [2:0] col_t;

  localparam int NUM_COLS = 7;
  localparam int NUM_ROWS = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_MOVE,
    S_WAIT_RAND,
    S_ISSUE,
    S_WAIT_RES,
    S_OVER
  } arb_state_t;

  function automatic player_t other_player(input player_t p);
    return (p == P1) ? P2 : P1;
  endfunction

endpackage

// File: rtl/turn_second_timer.sv
// Per-turn countdown: a clock prescaler feeding a saturating 4-bit seconds counter.
module turn_second_timer #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] value,
  input  logic       tick_en,
  output logic [3:0] count,
  output logic       expire
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [PW-1:0] presc;
  logic          tick;

  assign tick   = tick_en && (presc == PW'(TICKS_PER_SEC - 1));
  assign expire = tick && (count == 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      count <= '0;
    end else if (load) begin
      presc <= '0;
      count <= value;
    end else if (tick_en) begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick && count != 4'd0) count <= count - 4'd1;
    end
  end

endmodule

// File: rtl/connect4_turn_arbiter.sv
// Turn scheduler: arbitrates player move requests, enforces turn order and column
// legality, runs the turn countdown and issues one move per turn to the board datapath.
module connect4_turn_arbiter #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TURN_SECONDS  = 10,
  parameter int NUM_COLS      = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                first_player,
  input  logic                p1_valid,
  input  logic [2:0]          p1_col,
  output logic                p1_ready,
  input  logic                p2_valid,
  input  logic [2:0]          p2_col,
  output logic                p2_ready,
  input  logic [NUM_COLS-1:0] col_full,
  output logic                rand_req,
  input  logic                rand_valid,
  input  logic [2:0]          rand_col,
  output logic                mv_valid,
  output logic [2:0]          mv_col,
  output logic [1:0]          mv_player,
  input  logic                mv_ready,
  input  logic                res_valid,
  input  logic                res_win,
  input  logic                res_draw,
  output logic [1:0]          current_player,
  output logic [3:0]          turn_timer,
  output logic                timeout_pulse,
  output logic                illegal_pulse,
  output logic                match_over
);
  import connect4_pkg::*;

  // state      | meaning
  // S_IDLE     | no match since reset
  // S_WAIT_MOVE| active player's turn, countdown running
  // S_WAIT_RAND| turn expired, waiting for a legal random column
  // S_ISSUE    | move command offered to the datapath
  // S_WAIT_RES | waiting for placement / win-check result
  // S_OVER     | match finished, current_player holds winner (0 = draw)

  arb_state_t state_q, state_d;
  player_t    player_q, player_d;
  col_t       col_q, col_d;
  logic       illegal_d, timeout_d;
  logic       load, tick_en, expire;
  logic       p_accept, p_legal, rand_legal;
  col_t       req_col;
  logic [3:0] count;

  // Columns beyond NUM_COLS read as full, so out-of-range indices are rejected.
  function automatic logic col_legal(input col_t c, input logic [NUM_COLS-1:0] full);
    logic [7:0] full_ext;
    full_ext = {{(8 - NUM_COLS){1'b1}}, full};
    return !full_ext[c];
  endfunction

  assign p1_ready   = (state_q == S_WAIT_MOVE) && (player_q == P1);
  assign p2_ready   = (state_q == S_WAIT_MOVE) && (player_q == P2);
  assign req_col    = (player_q == P2) ? p2_col : p1_col;
  assign p_accept   = (p1_valid && p1_ready) || (p2_valid && p2_ready);
  assign p_legal    = col_legal(req_col, col_full);
  assign rand_legal = col_legal(rand_col, col_full);
  assign tick_en    = (state_q == S_WAIT_MOVE) && !(p_accept && p_legal);

  turn_second_timer #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .value   (4'(TURN_SECONDS)),
    .tick_en (tick_en),
    .count   (count),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      player_q      <= NONE;
      col_q         <= '0;
      illegal_pulse <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      player_q      <= player_d;
      col_q         <= col_d;
      illegal_pulse <= illegal_d;
      timeout_pulse <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    player_d  = player_q;
    col_d     = col_q;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    load      = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d  = S_WAIT_MOVE;
          player_d = first_player ? P2 : P1;
          load     = 1'b1;
        end
      end
      S_WAIT_MOVE: begin
        if (p_accept && p_legal) begin
          col_d   = req_col;
          state_d = S_ISSUE;
        end else begin
          illegal_d = p_accept;
          if (expire) begin
            timeout_d = 1'b1;
            state_d   = S_WAIT_RAND;
          end
        end
      end
      S_WAIT_RAND: begin
        if (rand_valid && rand_legal) begin
          col_d   = rand_col;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mv_ready) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (res_valid) begin
          if (res_win) begin
            state_d = S_OVER;
          end else if (res_draw) begin
            state_d  = S_OVER;
            player_d = NONE;
          end else begin
            state_d  = S_WAIT_MOVE;
            player_d = other_player(player_q);
            load     = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rand_req       = (state_q == S_WAIT_RAND);
  assign mv_valid       = (state_q == S_ISSUE);
  assign mv_col         = mv_valid ? col_q : '0;
  assign mv_player      = mv_valid ? player_q : NONE;
  assign current_player = player_q;
  assign turn_timer     = count;
  assign match_over     = (state_q == S_OVER);

endmodule

// File: tb/tb_connect4_turn_arbiter.sv
// Scoreboard bench for the turn arbiter: expected moves are queued when requests are
// driven and compared when the arbiter hands a move to the datapath.
module tb_connect4_turn_arbiter;
  import connect4_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, first_player = 1'b0;
  logic       p1_valid = 1'b0, p2_valid = 1'b0;
  logic [2:0] p1_col = '0, p2_col = '0;
  logic       p1_ready, p2_ready;
  logic [6:0] col_full = '0;
  logic       rand_req;
  logic       rand_valid = 1'b0;
  logic [2:0] rand_col = '0;
  logic       mv_valid;
  logic [2:0] mv_col;
  logic [1:0] mv_player;
  logic       mv_ready = 1'b1;
  logic       res_valid = 1'b0, res_win = 1'b0, res_draw = 1'b0;
  logic [1:0] current_player;
  logic [3:0] turn_timer;
  logic       timeout_pulse, illegal_pulse, match_over;

  int checks = 0;
  int failures = 0;
  logic [4:0] sb_q[$];

  connect4_turn_arbiter #(.TICKS_PER_SEC(4), .TURN_SECONDS(3), .NUM_COLS(7)) dut (
    .clk(clk), .rst(rst), .start(start), .first_player(first_player),
    .p1_valid(p1_valid), .p1_col(p1_col), .p1_ready(p1_ready),
    .p2_valid(p2_valid), .p2_col(p2_col), .p2_ready(p2_ready),
    .col_full(col_full), .rand_req(rand_req), .rand_valid(rand_valid), .rand_col(rand_col),
    .mv_valid(mv_valid), .mv_col(mv_col), .mv_player(mv_player), .mv_ready(mv_ready),
    .res_valid(res_valid), .res_win(res_win), .res_draw(res_draw),
    .current_player(current_player), .turn_timer(turn_timer),
    .timeout_pulse(timeout_pulse), .illegal_pulse(illegal_pulse), .match_over(match_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one legal request for the active player and answers with a result.
  task automatic do_move(input int pl, input int col, input bit win, input bit draw);
    if (pl == 1) begin p1_valid = 1'b1; p1_col = 3'(col); end
    else         begin p2_valid = 1'b1; p2_col = 3'(col); end
    sb_q.push_back({3'(col), 2'(pl)});
    step();
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    check("move_latency", mv_valid, 1);
    step();
    res_valid = 1'b1; res_win = win; res_draw = draw;
    step();
    res_valid = 1'b0; res_win = 1'b0; res_draw = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && mv_valid && mv_ready) begin
      if (sb_q.size() == 0) check("sb_unexpected_move", sb_q.size(), 1);
      else check("sb_move", {mv_col, mv_player}, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    check("rst_mv_valid", mv_valid, 0);
    check("rst_player", current_player, 0);
    check("rst_timer", turn_timer, 0);
    check("rst_ready", {p1_ready, p2_ready, rand_req, match_over}, 0);
    rst = 1'b1;
    step();

    // 1: P1 starts, legal move col 3, no win -> P2
    start = 1'b1; first_player = 1'b0;
    step();
    start = 1'b0;
    check("t1_player", current_player, 1);
    check("t1_timer", turn_timer, 3);
    check("t1_readys", {p1_ready, p2_ready}, 2'b10);
    p1_valid = 1'b1; p1_col = 3'd3;
    sb_q.push_back({3'd3, 2'd1});
    step();
    p1_valid = 1'b0;
    check("t1_mv_valid", mv_valid, 1);
    check("t1_mv_col", mv_col, 3);
    check("t1_mv_player", mv_player, 1);
    step();
    check("t1_wait_res", mv_valid, 0);
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    check("t1_toggle", current_player, 2);
    do_move(2, 0, 1'b0, 1'b0);

    // 2: out-of-turn P2 request is dropped
    p2_valid = 1'b1; p2_col = 3'd2;
    check("t2_p2_ready", p2_ready, 0);
    step();
    p2_valid = 1'b0;
    check("t2_no_move", mv_valid, 0);
    check("t2_still_p1", p1_ready, 1);
    do_move(1, 2, 1'b0, 1'b0);
    do_move(2, 4, 1'b0, 1'b0);

    // 3: full column and out-of-range column are illegal
    col_full = 7'b0100000;
    p1_valid = 1'b1; p1_col = 3'd5;
    step();
    p1_valid = 1'b0;
    check("t3_illegal_full", illegal_pulse, 1);
    check("t3_no_move", mv_valid, 0);
    check("t3_turn_kept", p1_ready, 1);
    step();
    check("t3_pulse_1cyc", illegal_pulse, 0);
    p1_valid = 1'b1; p1_col = 3'd7;
    step();
    p1_valid = 1'b0;
    check("t3_illegal_range", illegal_pulse, 1);
    do_move(1, 1, 1'b0, 1'b0);
    col_full = '0;

    // 4: P2 times out, random column retried until legal
    for (int k = 0; k < 12; k++) begin
      check("t4_timer", turn_timer, 3 - k / 4);
      check("t4_no_timeout", timeout_pulse, 0);
      step();
    end
    check("t4_timer_zero", turn_timer, 0);
    check("t4_timeout", timeout_pulse, 1);
    check("t4_rand_req", rand_req, 1);
    check("t4_ready_off", p2_ready, 0);
    col_full = 7'b1000000;
    rand_valid = 1'b1; rand_col = 3'd6;
    step();
    check("t4_rerequest", rand_req, 1);
    check("t4_timeout_1cyc", timeout_pulse, 0);
    check("t4_no_move", mv_valid, 0);
    rand_col = 3'd1;
    sb_q.push_back({3'd1, 2'd2});
    step();
    rand_valid = 1'b0;
    check("t4_mv_col", mv_col, 1);
    check("t4_rand_done", rand_req, 0);
    step();
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    col_full = '0;

    // 5: back-pressure, win, restart, draw
    mv_ready = 1'b0;
    p1_valid = 1'b1; p1_col = 3'd4;
    sb_q.push_back({3'd4, 2'd1});
    step();
    p1_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t5_hold", {mv_valid, mv_col, mv_player}, {1'b1, 3'd4, 2'd1});
      step();
    end
    mv_ready = 1'b1;
    step();
    res_valid = 1'b1; res_win = 1'b1;
    step();
    res_valid = 1'b0; res_win = 1'b0;
    check("t5_over", match_over, 1);
    check("t5_winner", current_player, 1);
    check("t5_readys_off", {p1_ready, p2_ready}, 0);
    start = 1'b1; first_player = 1'b1;
    step();
    start = 1'b0;
    check("t5_restart", {match_over, current_player, p2_ready}, {1'b0, 2'd2, 1'b1});
    check("t5_timer", turn_timer, 3);
    do_move(2, 0, 1'b0, 1'b1);
    check("t5_draw_over", match_over, 1);
    check("t5_draw_player", current_player, 0);

    // 6: asynchronous reset during ISSUE
    start = 1'b1; first_player = 1'b0;
    step();
    start = 1'b0;
    mv_ready = 1'b0;
    p1_valid = 1'b1; p1_col = 3'd5;
    sb_q.push_back({3'd5, 2'd1});
    step();
    p1_valid = 1'b0;
    check("t6_issue", mv_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_async_mv", {mv_valid, mv_col, mv_player}, 0);
    check("t6_async_state", {current_player, match_over, p1_ready, turn_timer}, 0);
    check("t6_aborted_move", sb_q.size(), 1);
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    mv_ready = 1'b1;
    step();
    check("t6_idle", {current_player, p1_ready, mv_valid}, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t6_restart", current_player, 1);

    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
